// File: rtl/readout_iq_demodulation_unit.sv
// Readout I/Q demodulator: mixes signed ADC samples with a writable sin/cos LUT
// stepped by a sample-indexed NCO and integrates the products per measurement.
module readout_iq_demodulation_unit #(
    parameter int LUT_NUM_ENTRY  = 1024,
    parameter int LUT_ADDR_WIDTH = 10,
    parameter int LUT_DATA_WIDTH = 8,
    parameter int SAMPLE_WIDTH   = 9,
    parameter int ACC_WIDTH      = 24,
    parameter int CNT_WIDTH      = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sin_lut_wr_en,
    input  logic                             cos_lut_wr_en,
    input  logic [LUT_ADDR_WIDTH-1:0]        sinusoidal_lut_wr_addr,
    input  logic [LUT_DATA_WIDTH-1:0]        sinusoidal_lut_wr_data,
    input  logic                             start,
    input  logic [LUT_ADDR_WIDTH-1:0]        ftw,
    input  logic [LUT_ADDR_WIDTH-1:0]        phase_offset,
    input  logic [CNT_WIDTH-1:0]             integ_len,
    input  logic                             valid_in,
    input  logic signed [SAMPLE_WIDTH-1:0]   i_in,
    input  logic signed [SAMPLE_WIDTH-1:0]   q_in,
    output logic                             busy,
    output logic signed [ACC_WIDTH-1:0]      i_acc_out,
    output logic signed [ACC_WIDTH-1:0]      q_acc_out,
    output logic                             valid_out
);

    localparam int PROD_W = SAMPLE_WIDTH + LUT_DATA_WIDTH;
    localparam int SUM_W  = PROD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INTEG,
        ST_DRAIN
    } state_t;

    state_t r_state;

    logic signed [LUT_DATA_WIDTH-1:0] r_sin_lut [LUT_NUM_ENTRY];
    logic signed [LUT_DATA_WIDTH-1:0] r_cos_lut [LUT_NUM_ENTRY];

    logic [LUT_ADDR_WIDTH-1:0]      r_ftw;
    logic [LUT_ADDR_WIDTH-1:0]      r_phase_offset;
    logic [CNT_WIDTH-1:0]           r_integ_len;
    logic [LUT_ADDR_WIDTH-1:0]      r_nco;
    logic [CNT_WIDTH-1:0]           r_cnt;
    logic [1:0]                     r_drain_cnt;
    logic signed [ACC_WIDTH-1:0]    r_i_acc;
    logic signed [ACC_WIDTH-1:0]    r_q_acc;
    logic signed [ACC_WIDTH-1:0]    r_i_out;
    logic signed [ACC_WIDTH-1:0]    r_q_out;
    logic                           r_valid_out;

    logic                           r_s0_valid;
    logic signed [SAMPLE_WIDTH-1:0] r_s0_i;
    logic signed [SAMPLE_WIDTH-1:0] r_s0_q;
    logic [LUT_ADDR_WIDTH-1:0]      r_s0_phase;

    logic                             r_s1_valid;
    logic signed [SAMPLE_WIDTH-1:0]   r_s1_i;
    logic signed [SAMPLE_WIDTH-1:0]   r_s1_q;
    logic signed [LUT_DATA_WIDTH-1:0] r_s1_cos;
    logic signed [LUT_DATA_WIDTH-1:0] r_s1_sin;

    logic                    r_s2_valid;
    logic signed [SUM_W-1:0] r_s2_i;
    logic signed [SUM_W-1:0] r_s2_q;

    logic                     w_accept;
    logic [CNT_WIDTH-1:0]     w_cnt_next;
    logic signed [PROD_W-1:0] w_ic;
    logic signed [PROD_W-1:0] w_qs;
    logic signed [PROD_W-1:0] w_qc;
    logic signed [PROD_W-1:0] w_is;
    logic signed [SUM_W-1:0]  w_i_sum;
    logic signed [SUM_W-1:0]  w_q_sum;

    assign w_accept   = (r_state == ST_INTEG) && valid_in;
    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);

    // Operands widened first so the products keep full precision.
    assign w_ic    = PROD_W'(r_s1_i) * PROD_W'(r_s1_cos);
    assign w_qs    = PROD_W'(r_s1_q) * PROD_W'(r_s1_sin);
    assign w_qc    = PROD_W'(r_s1_q) * PROD_W'(r_s1_cos);
    assign w_is    = PROD_W'(r_s1_i) * PROD_W'(r_s1_sin);
    assign w_i_sum = SUM_W'(w_ic) + SUM_W'(w_qs);
    assign w_q_sum = SUM_W'(w_qc) - SUM_W'(w_is);

    assign busy      = (r_state != ST_IDLE);
    assign i_acc_out = r_i_out;
    assign q_acc_out = r_q_out;
    assign valid_out = r_valid_out;

    always_ff @(posedge clk) begin
        if (sin_lut_wr_en) r_sin_lut[sinusoidal_lut_wr_addr] <= sinusoidal_lut_wr_data;
        if (cos_lut_wr_en) r_cos_lut[sinusoidal_lut_wr_addr] <= sinusoidal_lut_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_i     <= '0;
            r_s0_q     <= '0;
            r_s0_phase <= '0;
            r_s1_valid <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
            r_s1_cos   <= '0;
            r_s1_sin   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_i     <= '0;
            r_s2_q     <= '0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_i     <= i_in;
                r_s0_q     <= q_in;
                r_s0_phase <= r_nco + r_phase_offset;
            end
            r_s1_valid <= r_s0_valid;
            r_s1_i     <= r_s0_i;
            r_s1_q     <= r_s0_q;
            r_s1_cos   <= r_cos_lut[r_s0_phase];
            r_s1_sin   <= r_sin_lut[r_s0_phase];
            r_s2_valid <= r_s1_valid;
            r_s2_i     <= w_i_sum;
            r_s2_q     <= w_q_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ftw          <= '0;
            r_phase_offset <= '0;
            r_integ_len    <= '0;
            r_nco          <= '0;
            r_cnt          <= '0;
            r_drain_cnt    <= '0;
            r_i_acc        <= '0;
            r_q_acc        <= '0;
            r_i_out        <= '0;
            r_q_out        <= '0;
            r_valid_out    <= 1'b0;
        end else begin
            r_valid_out <= 1'b0;
            if (r_s2_valid) begin
                r_i_acc <= r_i_acc + ACC_WIDTH'(r_s2_i);
                r_q_acc <= r_q_acc + ACC_WIDTH'(r_s2_q);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ftw          <= ftw;
                        r_phase_offset <= phase_offset;
                        r_integ_len    <= integ_len;
                        r_nco          <= '0;
                        r_cnt          <= '0;
                        r_drain_cnt    <= '0;
                        r_i_acc        <= '0;
                        r_q_acc        <= '0;
                        r_state        <= (integ_len == '0) ? ST_DRAIN : ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    if (valid_in) begin
                        r_nco <= r_nco + r_ftw;
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == r_integ_len) begin
                            r_drain_cnt <= '0;
                            r_state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Four edges cover the three pipeline stages behind the last accept.
                    if (r_drain_cnt == 2'd3) begin
                        r_i_out     <= r_i_acc;
                        r_q_out     <= r_q_acc;
                        r_valid_out <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_readout_iq_demodulation_unit.sv
// Scoreboard bench for readout_iq_demodulation_unit: expected integrals come from
// a reference LUT model and are popped when valid_out fires.
module tb_readout_iq_demodulation_unit;

    localparam int LUT_N = 1024;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int SW    = 9;
    localparam int ACCW  = 24;
    localparam int CW    = 12;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   sin_lut_wr_en;
    logic                   cos_lut_wr_en;
    logic [AW-1:0]          sinusoidal_lut_wr_addr;
    logic [DW-1:0]          sinusoidal_lut_wr_data;
    logic                   start;
    logic [AW-1:0]          ftw;
    logic [AW-1:0]          phase_offset;
    logic [CW-1:0]          integ_len;
    logic                   valid_in;
    logic signed [SW-1:0]   i_in;
    logic signed [SW-1:0]   q_in;
    logic                   busy;
    logic signed [ACCW-1:0] i_acc_out;
    logic signed [ACCW-1:0] q_acc_out;
    logic                   valid_out;

    always #5 clk = ~clk;

    readout_iq_demodulation_unit #(
        .LUT_NUM_ENTRY (LUT_N),
        .LUT_ADDR_WIDTH(AW),
        .LUT_DATA_WIDTH(DW),
        .SAMPLE_WIDTH  (SW),
        .ACC_WIDTH     (ACCW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .sin_lut_wr_en         (sin_lut_wr_en),
        .cos_lut_wr_en         (cos_lut_wr_en),
        .sinusoidal_lut_wr_addr(sinusoidal_lut_wr_addr),
        .sinusoidal_lut_wr_data(sinusoidal_lut_wr_data),
        .start                 (start),
        .ftw                   (ftw),
        .phase_offset          (phase_offset),
        .integ_len             (integ_len),
        .valid_in              (valid_in),
        .i_in                  (i_in),
        .q_in                  (q_in),
        .busy                  (busy),
        .i_acc_out             (i_acc_out),
        .q_acc_out             (q_acc_out),
        .valid_out             (valid_out)
    );

    typedef struct {
        longint ei;
        longint eq;
        int     ecyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   model_cos[LUT_N];
    int   model_sin[LUT_N];
    int   si[512];
    int   sq[512];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("i_acc_out", longint'(i_acc_out), mon_e.ei);
                check("q_acc_out", longint'(q_acc_out), mon_e.eq);
                check("result_latency", cyc, mon_e.ecyc);
            end
        end
    end

    // mode 0: cos=127 sin=0; mode 1: cos=0 sin=127; mode 2: cos quarter-step ramp 1..4
    task automatic fill_lut(input int mode);
        for (int a = 0; a < LUT_N; a++) begin
            case (mode)
                0:       begin model_cos[a] = 127; model_sin[a] = 0;   end
                1:       begin model_cos[a] = 0;   model_sin[a] = 127; end
                default: begin model_cos[a] = (a % 256 == 0) ? a / 256 + 1 : 0; model_sin[a] = 0; end
            endcase
        end
        for (int a = 0; a < LUT_N; a++) begin
            cos_lut_wr_en          = 1'b1;
            sinusoidal_lut_wr_addr = AW'(a);
            sinusoidal_lut_wr_data = DW'(model_cos[a]);
            tick();
        end
        cos_lut_wr_en = 1'b0;
        for (int a = 0; a < LUT_N; a++) begin
            sin_lut_wr_en          = 1'b1;
            sinusoidal_lut_wr_addr = AW'(a);
            sinusoidal_lut_wr_data = DW'(model_sin[a]);
            tick();
        end
        sin_lut_wr_en = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            tick();
            t++;
        end
        check("measurement_done", longint'(sb.size() == 0 && !busy), 1);
        tick();
    endtask

    // abort_at > 0 stops driving after that many samples without queueing a result.
    task automatic run_meas(input int ftw_v, input int off, input int len, input int gap,
                            input bit spurious, input int abort_at);
        longint ai = 0;
        longint aq = 0;
        logic signed [ACCW-1:0] ti;
        logic signed [ACCW-1:0] tq;
        exp_t e;
        int p;
        int nbusy = 0;
        start        = 1'b1;
        ftw          = AW'(ftw_v);
        phase_offset = AW'(off);
        integ_len    = CW'(len);
        if (len == 0) begin
            e.ei = 0; e.eq = 0; e.ecyc = cyc + 5;
            sb.push_back(e);
            tick();
            start = 1'b0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (busy) nbusy++;
            end
            check("zero_len_busy_cycles", nbusy, 4);
            wait_done();
            return;
        end
        tick();
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (abort_at > 0 && k == abort_at) return;
            p  = (k * ftw_v + off) % LUT_N;
            ai += longint'(si[k] * model_cos[p] + sq[k] * model_sin[p]);
            aq += longint'(sq[k] * model_cos[p] - si[k] * model_sin[p]);
            valid_in = 1'b1;
            i_in     = SW'(si[k]);
            q_in     = SW'(sq[k]);
            if (spurious && k == 1) begin
                start        = 1'b1;
                ftw          = AW'(ftw_v + 37);
                phase_offset = AW'(off + 100);
                integ_len    = CW'(1);
            end
            if (k == len - 1) begin
                ti = ai[ACCW-1:0];
                tq = aq[ACCW-1:0];
                e.ei = longint'(ti); e.eq = longint'(tq); e.ecyc = cyc + 5;
                sb.push_back(e);
            end
            tick();
            valid_in = 1'b0;
            start    = 1'b0;
            repeat (gap) tick();
        end
        wait_done();
    endtask

    task automatic set_samples(input int n, input int iv, input int qv);
        for (int k = 0; k < n; k++) begin
            si[k] = iv;
            sq[k] = qv;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sin_lut_wr_en = 1'b0; cos_lut_wr_en = 1'b0;
        sinusoidal_lut_wr_addr = '0; sinusoidal_lut_wr_data = '0;
        start = 1'b0; ftw = '0; phase_offset = '0; integ_len = '0;
        valid_in = 1'b0; i_in = '0; q_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_valid_out", longint'(valid_out), 0);
        check("reset_i_acc_out", longint'(i_acc_out), 0);
        check("reset_q_acc_out", longint'(q_acc_out), 0);
        tick();
        rst_n = 1'b1;
        tick();

        fill_lut(0);
        set_samples(4, 10, -5);
        run_meas(0, 0, 4, 0, 1'b0, 0);

        fill_lut(1);
        run_meas(0, 0, 4, 0, 1'b0, 0);

        fill_lut(2);
        set_samples(4, 1, 0);
        run_meas(256, 0, 4, 2, 1'b0, 0);
        run_meas(256, 256, 4, 2, 1'b0, 0);
        for (int k = 0; k < 4; k++) si[k] = k + 1;
        run_meas(256, 256, 4, 2, 1'b0, 0);

        run_meas(0, 0, 0, 0, 1'b0, 0);

        fill_lut(0);
        for (int n = 0; n < 5; n++) begin
            valid_in = 1'b1;
            i_in     = SW'(100 + n);
            q_in     = SW'(-77);
            tick();
        end
        valid_in = 1'b0;
        set_samples(4, 10, -5);
        run_meas(0, 0, 4, 1, 1'b1, 0);

        run_meas(0, 0, 4, 0, 1'b0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", longint'(busy), 0);
        check("abort_valid_out", longint'(valid_out), 0);
        check("abort_i_acc_out", longint'(i_acc_out), 0);
        check("abort_q_acc_out", longint'(q_acc_out), 0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        run_meas(0, 0, 4, 0, 1'b0, 0);

        set_samples(300, -256, 255);
        run_meas(3, 5, 300, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/readout_iq_demodulation_unit.md
Name: readout_iq_demodulation_unit

Overview:
Receive-side counterpart of the drive modulation path. It takes signed I/Q ADC samples and mixes them down with a writable sin/cos LUT driven by an internal sample-indexed NCO. It integrates the mixed products over a programmable number of accepted samples and emits one integrated I/Q pair per measurement. It sits between the readout ADC interface and the state discriminator.

Parameters:
LUT_NUM_ENTRY, 1024, entries per sin/cos LUT
LUT_ADDR_WIDTH, 10, LUT address / phase width (phase modulo 2^LUT_ADDR_WIDTH)
LUT_DATA_WIDTH, 8, signed two's-complement LUT word width
SAMPLE_WIDTH, 9, signed I/Q input sample width
ACC_WIDTH, 24, signed accumulator and result width
CNT_WIDTH, 12, integration-length counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
sin_lut_wr_en  in  1  write enable, sin LUT
cos_lut_wr_en  in  1  write enable, cos LUT
sinusoidal_lut_wr_addr  in  LUT_ADDR_WIDTH  shared LUT write address
sinusoidal_lut_wr_data  in  LUT_DATA_WIDTH  shared LUT write data
start  in  1  begin measurement (honoured only in IDLE)
ftw  in  LUT_ADDR_WIDTH  NCO phase increment per accepted sample, latched on start
phase_offset  in  LUT_ADDR_WIDTH  constant phase added to NCO, latched on start
integ_len  in  CNT_WIDTH  number of samples to integrate, latched on start
valid_in  in  1  sample qualifier
i_in  in  SAMPLE_WIDTH  signed I sample
q_in  in  SAMPLE_WIDTH  signed Q sample
busy  out  1  high in INTEG and DRAIN
i_acc_out  out  ACC_WIDTH  signed integrated I result
q_acc_out  out  ACC_WIDTH  signed integrated Q result
valid_out  out  1  one-cycle pulse: new result on i_acc_out/q_acc_out

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. Accumulators, NCO, counters and pipeline valids = 0. busy=0, valid_out=0, i_acc_out=0, q_acc_out=0. LUT contents are not reset.
- LUTs: synchronous write, combinational read, writable in any state. A write is visible to reads from the next cycle.
- FSM states: IDLE, INTEG, DRAIN.
- IDLE, start=1 at edge E0:
  - latch ftw, phase_offset, integ_len; clear accumulators, NCO phase and sample count.
  - go to INTEG, or to DRAIN if integ_len==0.
- start outside IDLE is ignored.
- INTEG: sample accepted on each edge with valid_in=1. valid_in outside INTEG is ignored.
- Accepted sample k (k from 0) uses phase p_k = (k*ftw + phase_offset) mod 2^LUT_ADDR_WIDTH. The NCO advances only on accepted samples, so gaps do not shift phase.
- The edge accepting sample integ_len-1 moves the FSM to DRAIN.
- Pipeline, for a sample accepted at edge Ea:
  - Ea: sample and p_k registered.
  - Ea+1: cos[p_k] and sin[p_k] registered with the sample.
  - Ea+2: products registered:
    - I' = i*cos + q*sin
    - Q' = q*cos - i*sin
    - each product SAMPLE_WIDTH+LUT_DATA_WIDTH bits; sum one bit wider; full precision, no truncation.
  - Ea+3: I'/Q' sign-extended to ACC_WIDTH and added to the accumulators. Accumulation wraps modulo 2^ACC_WIDTH (no saturation).
- DRAIN: lasts exactly 4 cycles from the edge that entered it. On the 4th edge:
  - i_acc_out/q_acc_out <= accumulators; valid_out=1 for one cycle.
  - FSM -> IDLE, busy=0.
  - Results hold until the next result or reset.
- Result latency: valid_out rises 4 edges after the final accepted sample (4 edges after E0 when integ_len==0, with zero results).
- start arriving in the same cycle that valid_out is high is honoured, because the FSM is in IDLE.
- Reset mid-measurement aborts with no valid_out. Outputs return to 0.

Test Plan:
- All cos=127, all sin=0; ftw=0, integ_len=4; four samples i=10, q=-5 -> valid_out 4 edges after the 4th sample; i_acc_out=5080, q_acc_out=-2540.
- All cos=0, all sin=127; same stimulus -> i_acc_out=-2540, q_acc_out=-5080.
- cos[0]=1, cos[256]=2, cos[512]=3, cos[768]=4, all other cos entries and all sin=0; ftw=256, phase_offset=0, integ_len=4, i=1, q=0, valid_in toggling with 2-cycle gaps -> i_acc_out=10, q_acc_out=0. Repeat with phase_offset=256 -> i_acc_out=10 (rotated order). Confirms per-sample NCO stepping.
- integ_len=0, start pulse -> busy high 4 cycles; valid_out at E0+4; results 0.
- start pulsed again during INTEG, and valid_in pulses in IDLE -> no effect; result identical to the first test.
- rst_n low for 1 cycle after 2 of 4 samples -> busy=0, outputs 0, no valid_out. A fresh start then gives the first-test result.
